// File: rtl/bank_scheduler.sv
// Two-bank packet write scheduler.
// Each accepted descriptor is placed in one of two RAM banks, alternating
// between banks when both have room. The block then issues a single AXI-style
// write command for the packet and waits for that command to be taken.
// Packets that fit in neither bank, or that are longer than MAX_BEATS, are
// dropped and counted.
module bank_scheduler #(
  parameter logic [63:0] BANK0_BASE = 64'h0,
  parameter logic [63:0] BANK1_BASE = 64'h1_0000_0000,
  parameter logic [63:0] BANK_SIZE  = 64'h1_0000_0000,
  parameter logic [15:0] MAX_BEATS  = 16'd150
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pkt_len,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  output logic        cmd_bank,
  output logic [63:0] cmd_addr,
  output logic [15:0] cmd_beats,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        pkt_drop,
  output logic [31:0] drop_count,
  output logic [31:0] pkt_count,
  output logic [63:0] bank0_used,
  output logic [63:0] bank1_used,
  output logic        full
);

  typedef enum logic {IDLE, CMD} state_t;

  // Byte size of the largest legal packet; used for the full flag.
  localparam logic [63:0] MAX_BYTES = {48'd0, MAX_BEATS} << 6;

  state_t      state, state_next;
  logic        pref, pref_next;
  logic        cmd_bank_next;
  logic [63:0] cmd_addr_next;
  logic [15:0] cmd_beats_next;
  logic        cmd_valid_next;
  logic        pkt_drop_next;
  logic [31:0] drop_count_next;
  logic [31:0] pkt_count_next;
  logic [63:0] bank0_used_next;
  logic [63:0] bank1_used_next;
  logic        full_next;

  logic        accept;
  logic [63:0] bytes;
  logic [63:0] free0;
  logic [63:0] free1;
  logic        fit0;
  logic        fit1;
  logic        pref_fit;
  logic        other_fit;
  logic        too_long;
  logic        alloc;
  logic        chosen;
  logic        drop;

  // Only one descriptor can be in flight, and never while reset is asserted.
  assign pkt_ready = (state == IDLE) & enable & ~reset;
  assign accept    = pkt_valid & pkt_ready;

  // Packet size in bytes and the room left in each bank. Used values never
  // exceed BANK_SIZE, so the subtractions cannot wrap.
  assign bytes     = {48'd0, pkt_len} << 6;
  assign free0     = BANK_SIZE - bank0_used;
  assign free1     = BANK_SIZE - bank1_used;
  assign fit0      = (free0 >= bytes);
  assign fit1      = (free1 >= bytes);
  assign pref_fit  = pref ? fit1 : fit0;
  assign other_fit = pref ? fit0 : fit1;
  assign too_long  = (pkt_len > MAX_BEATS);

  // Next-state and datapath decisions: allocate, drop, or retire a command.
  always_comb begin
    state_next      = state;
    pref_next       = pref;
    cmd_bank_next   = cmd_bank;
    cmd_addr_next   = cmd_addr;
    cmd_beats_next  = cmd_beats;
    cmd_valid_next  = cmd_valid;
    pkt_drop_next   = 1'b0;
    drop_count_next = drop_count;
    pkt_count_next  = pkt_count;
    bank0_used_next = bank0_used;
    bank1_used_next = bank1_used;
    alloc           = 1'b0;
    chosen          = 1'b0;
    drop            = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (too_long) begin
            drop = 1'b1;
          end else if (pkt_len != 16'd0) begin
            if (pref_fit) begin
              alloc  = 1'b1;
              chosen = pref;
            end else if (other_fit) begin
              alloc  = 1'b1;
              chosen = ~pref;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      CMD: begin
        if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          state_next     = IDLE;
          if (pkt_count != 32'hFFFF_FFFF) begin
            pkt_count_next = pkt_count + 32'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (alloc) begin
      cmd_bank_next  = chosen;
      cmd_beats_next = pkt_len;
      cmd_valid_next = 1'b1;
      pref_next      = ~chosen;
      state_next     = CMD;
      if (chosen) begin
        cmd_addr_next   = BANK1_BASE + bank1_used;
        bank1_used_next = bank1_used + bytes;
      end else begin
        cmd_addr_next   = BANK0_BASE + bank0_used;
        bank0_used_next = bank0_used + bytes;
      end
    end

    if (drop) begin
      pkt_drop_next = 1'b1;
      if (drop_count != 32'hFFFF_FFFF) begin
        drop_count_next = drop_count + 32'd1;
      end
    end

    full_next = ((BANK_SIZE - bank0_used_next) < MAX_BYTES) &
                ((BANK_SIZE - bank1_used_next) < MAX_BYTES);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command, counter and bank-occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pref       <= 1'b0;
      cmd_bank   <= 1'b0;
      cmd_addr   <= 64'd0;
      cmd_beats  <= 16'd0;
      cmd_valid  <= 1'b0;
      pkt_drop   <= 1'b0;
      drop_count <= 32'd0;
      pkt_count  <= 32'd0;
      bank0_used <= 64'd0;
      bank1_used <= 64'd0;
      full       <= 1'b0;
    end else begin
      pref       <= pref_next;
      cmd_bank   <= cmd_bank_next;
      cmd_addr   <= cmd_addr_next;
      cmd_beats  <= cmd_beats_next;
      cmd_valid  <= cmd_valid_next;
      pkt_drop   <= pkt_drop_next;
      drop_count <= drop_count_next;
      pkt_count  <= pkt_count_next;
      bank0_used <= bank0_used_next;
      bank1_used <= bank1_used_next;
      full       <= full_next;
    end
  end

endmodule
